// File: rtl/sbus_pkg.sv
// Shared types and helpers for the SBUS memory responder.
//   sbus_word_t   : 36-bit data word
//   sbus_adr_t    : 22-bit word address, bit 21 = PMA bit 14, bit 0 = PMA bit 35
//   sbus_mem_st_t : responder FSM state
//   oddpar        : parity bit that makes {word, bit} odd
//   first_pos     : first set mask position at or after a pointer, scanning mod 4
package sbus_pkg;

    typedef logic [35:0] sbus_word_t;
    typedef logic [21:0] sbus_adr_t;

    typedef enum logic [2:0] {
        StIdle,
        StAckWait,
        StRdWait,
        StRdXfer,
        StWrXfer
    } sbus_mem_st_t;

    function automatic logic oddpar(input sbus_word_t w);
        return ~(^w);
    endfunction

    // Scan from the highest offset down so the nearest set position wins.
    // Returns 'from' when the mask is empty.
    function automatic logic [1:0] first_pos(input logic [3:0] mask, input logic [1:0] from);
        logic [1:0] p;
        logic [1:0] r;
        r = from;
        for (int i = 3; i >= 0; i--) begin
            p = from + 2'(i);
            if (mask[p]) begin
                r = p;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sbus_mem_array.sv
// Single-port word array for sbus_mem: 2^ADR_BITS x 37 bits ({parity, data}).
//   clk   : clock, rising edge
//   we    : write enable, writes wdata at addr
//   re    : read enable, rdata holds mem[addr] from the next cycle
//   addr  : word index
//   wdata : {parity, data} to store
//   rdata : registered read data
module sbus_mem_array #(
    parameter int unsigned ADR_BITS = 14
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [ADR_BITS-1:0] addr,
    input  logic [36:0]         wdata,
    output logic [36:0]         rdata
);

    logic [36:0] mem [2**ADR_BITS];
    logic [36:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sbus_mem.sv
// SBUS memory-side responder. Accepts quadword read, write and read-pause-write
// requests on cable A or B, acknowledges them and streams words to/from a
// parity-tagged array.
//   clk, crobar, mem_reset           : clock, sync reset, sync abort (array kept)
//   start_a/b, rq, rd_rq, wr_rq,
//   diag, adr, adr_par               : request from the MBOX
//   d_in, data_par_in,
//   data_valid_a_in/b_in             : write words and their strobes
//   ackn_a/b                         : request acknowledge
//   data_valid_a_out/b_out, d_out,
//   data_par_out                     : read words
//   error, adr_par_err               : address parity error pulse
module sbus_mem
    import sbus_pkg::*;
#(
    parameter int unsigned ADR_BITS = 14,
    parameter int unsigned ACK_DLY  = 2,
    parameter int unsigned RD_DLY   = 3
) (
    input  logic       clk,
    input  logic       crobar,
    input  logic       mem_reset,
    input  logic       start_a,
    input  logic       start_b,
    input  logic [3:0] rq,
    input  logic       rd_rq,
    input  logic       wr_rq,
    input  logic       diag,
    input  sbus_adr_t  adr,
    input  logic       adr_par,
    input  sbus_word_t d_in,
    input  logic       data_par_in,
    input  logic       data_valid_a_in,
    input  logic       data_valid_b_in,
    output logic       ackn_a,
    output logic       ackn_b,
    output logic       data_valid_a_out,
    output logic       data_valid_b_out,
    output sbus_word_t d_out,
    output logic       data_par_out,
    output logic       error,
    output logic       adr_par_err
);

    sbus_mem_st_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         cable_b_q, cable_b_d;
    logic [ADR_BITS-3:0] quad_q, quad_d;
    logic [1:0]   start_q, start_d;
    logic [3:0]   rq_q, rq_d;
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [3:0]   rem_q, rem_d;
    logic         perr_q, perr_d;

    logic [1:0]   pos;
    logic [3:0]   rem_clr;
    logic         issue;
    logic         strobe_in;
    logic         nxm;
    logic         ram_we;
    logic         ram_re;
    logic [36:0]  ram_rdata;
    logic         ackn;
    logic         rvalid;

    // Any address bit above the implemented range means nonexistent memory.
    assign nxm = |(adr >> ADR_BITS);

    // Next requested position still outstanding; shared by read issue and write.
    assign pos       = first_pos(rem_q, ptr_q);
    assign rem_clr   = rem_q & ~(4'b0001 << pos);
    assign strobe_in = cable_b_q ? data_valid_b_in : data_valid_a_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cable_b_d = cable_b_q;
        quad_d    = quad_q;
        start_d   = start_q;
        rq_d      = rq_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        perr_d    = 1'b0;
        issue     = 1'b0;
        ram_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if ((start_a || start_b) && !diag) begin
                    if (!(^{adr, adr_par})) begin
                        perr_d = 1'b1;
                    end else if (!nxm) begin
                        state_d   = StAckWait;
                        cnt_d     = 4'(ACK_DLY);
                        cable_b_d = ~start_a;
                        quad_d    = adr[ADR_BITS-1:2];
                        start_d   = adr[1:0];
                        rq_d      = rq;
                        rd_d      = rd_rq;
                        wr_d      = wr_rq;
                        ptr_d     = adr[1:0];
                        rem_d     = rq;
                    end
                end
            end
            StAckWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (rq_q == 4'd0) begin
                    state_d = StIdle;
                end else if (rd_q) begin
                    // The array read is issued the cycle before its word is valid.
                    if (RD_DLY == 1) begin
                        state_d = StRdXfer;
                        issue   = 1'b1;
                    end else begin
                        state_d = StRdWait;
                        cnt_d   = 4'(RD_DLY) - 4'd2;
                    end
                end else begin
                    state_d = StWrXfer;
                end
            end
            StRdWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StRdXfer;
                    issue   = 1'b1;
                end
            end
            StRdXfer: begin
                if (rem_q != 4'd0) begin
                    issue = 1'b1;
                end else if (wr_q) begin
                    // Read-pause-write: rerun the same mask for the write half.
                    state_d = StWrXfer;
                    rem_d   = rq_q;
                    ptr_d   = start_q;
                end else begin
                    state_d = StIdle;
                end
            end
            StWrXfer: begin
                if (strobe_in) begin
                    ram_we = 1'b1;
                    rem_d  = rem_clr;
                    ptr_d  = pos + 2'd1;
                    if (rem_clr == 4'd0) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            rem_d = rem_clr;
            ptr_d = pos + 2'd1;
        end

        if (crobar || mem_reset) begin
            state_d = StIdle;
            perr_d  = 1'b0;
            issue   = 1'b0;
            ram_we  = 1'b0;
        end
    end

    assign ram_re = issue;

    always_ff @(posedge clk) begin
        if (crobar) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cable_b_q <= 1'b0;
            quad_q    <= '0;
            start_q   <= '0;
            rq_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ptr_q     <= '0;
            rem_q     <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cable_b_q <= cable_b_d;
            quad_q    <= quad_d;
            start_q   <= start_d;
            rq_q      <= rq_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            perr_q    <= perr_d;
        end
    end

    sbus_mem_array #(
        .ADR_BITS(ADR_BITS)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr ({quad_q, pos}),
        .wdata({data_par_in, d_in}),
        .rdata(ram_rdata)
    );

    assign ackn             = (state_q == StAckWait) && (cnt_q == 4'd0);
    assign rvalid           = (state_q == StRdXfer);
    assign ackn_a           = ackn && !cable_b_q;
    assign ackn_b           = ackn && cable_b_q;
    assign data_valid_a_out = rvalid && !cable_b_q;
    assign data_valid_b_out = rvalid && cable_b_q;
    assign d_out            = rvalid ? ram_rdata[35:0] : '0;
    assign data_par_out     = rvalid ? ram_rdata[36] : 1'b0;
    assign error            = perr_q;
    assign adr_par_err      = perr_q;

endmodule
